jump_button_conditioner: RTL and testbench

Conditions the raw asynchronous `up_button` into clean jump events for the Dino processor wrapper. Synchronises, debounces, and edge-detects the button. Holds a sticky jump request until the processor acknowledges it, and keeps press statistics for the game loop. Sits directly upstream of the processor wrapper, between the board pin and the wrapper's button input.

---
 rtl/jump_button_conditioner.sv | 102 ++++++++++
 tb/tb_jump_button_conditioner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_button_conditioner.sv
// jump_button_conditioner: synchronise, debounce and edge-detect up_button into sticky jump requests
// Ports: clk, reset (sync, active-low), up_button (raw async), jump_ack (request consumed pulse),
//        button_level (debounced level), press_pulse (one cycle per event), jump_req (sticky request),
//        overrun (press arrived while request pending), press_count (wrapping event count).
// Option: define JUMP_AUTOREPEAT_EN to re-issue events every REPEAT_CYCLES while held.
module jump_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES = 12500000,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic up_button,
  input  logic jump_ack,
  output logic button_level,
  output logic press_pulse,
  output logic jump_req,
  output logic overrun,
  output logic [CNT_W-1:0] press_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, HELD, RELEASE_PEND} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync2_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic press_pulse_q, press_pulse_d, jump_req_q, jump_req_d, overrun_q, overrun_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic accept, ev;
  // The entry edge into a pending state already counts as the first stable cycle.
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    accept = 1'b0;
    case (state_q)
      RELEASED: if (sync2_q) begin
        state_d = PRESS_PEND;
        cnt_d = DW'(1);
      end
      PRESS_PEND: if (!sync2_q) state_d = RELEASED;
        else if (cnt_q == D_LAST) begin
          state_d = HELD;
          accept = 1'b1;
        end else cnt_d = cnt_q + DW'(1);
      HELD: if (!sync2_q) begin
        state_d = RELEASE_PEND;
        cnt_d = DW'(1);
      end
      RELEASE_PEND: if (sync2_q) state_d = HELD;
        else if (cnt_q == D_LAST) state_d = RELEASED;
        else cnt_d = cnt_q + DW'(1);
      default: state_d = RELEASED;
    endcase
  end
`ifdef JUMP_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rpt_q, rpt_d;
  logic rpt_ev;
  // Repeat counter only runs while staying in HELD; any exit restarts it from zero.
  always_comb begin
    rpt_ev = state_q == HELD && sync2_q && rpt_q == RW'(REPEAT_CYCLES - 1);
    rpt_d = (state_q == HELD && sync2_q && !rpt_ev) ? rpt_q + RW'(1) : '0;
  end
  always_ff @(posedge clk) rpt_q <= !reset ? '0 : rpt_d;
  assign ev = accept | rpt_ev;
`else
  assign ev = accept;
`endif
  // A new event wins over an acknowledge in the same cycle.
  always_comb begin
    press_pulse_d = ev;
    jump_req_d = ev ? 1'b1 : (jump_ack ? 1'b0 : jump_req_q);
    overrun_d = jump_ack ? 1'b0 : (overrun_q | (ev & jump_req_q));
    press_count_d = ev ? press_count_q + CNT_W'(1) : press_count_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RELEASED;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q <= '0;
      press_pulse_q <= 1'b0;
      jump_req_q <= 1'b0;
      overrun_q <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= up_button;
      sync2_q <= sync1_q;
      cnt_q <= cnt_d;
      press_pulse_q <= press_pulse_d;
      jump_req_q <= jump_req_d;
      overrun_q <= overrun_d;
      press_count_q <= press_count_d;
    end
  end
  assign button_level = state_q == HELD || state_q == RELEASE_PEND;
  assign press_pulse = press_pulse_q;
  assign jump_req = jump_req_q;
  assign overrun = overrun_q;
  assign press_count = press_count_q;
endmodule

// File: tb/tb_jump_button_conditioner.sv
// tb_jump_button_conditioner: scoreboard bench for jump_button_conditioner
module tb_jump_button_conditioner;
  logic clk = 1'b0, reset = 1'b0, up_button = 1'b0, jump_ack = 1'b0;
  logic button_level, press_pulse, jump_req, overrun;
  logic [3:0] press_count;
  int n_cmp = 0, n_err = 0;
  logic [3:0] exp_q[$];
  jump_button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .up_button(up_button), .jump_ack(jump_ack),
    .button_level(button_level), .press_pulse(press_pulse), .jump_req(jump_req),
    .overrun(overrun), .press_count(press_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (reset && press_pulse) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pulse_unexpected: got pulse count=%0d, expected no pulse", press_count);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (press_count !== e) begin
          n_err++;
          $display("FAIL pulse_count: got %0d, expected %0d", press_count, e);
        end
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    up_button = 1'b0;
    jump_ack = 1'b0;
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
  endtask
  task automatic do_press(input logic [3:0] cnt);
    up_button = 1'b1;
    exp_q.push_back(cnt);
    cyc(6);
    up_button = 1'b0;
    cyc(7);
  endtask
  task automatic test_reset();
    up_button = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      n_cmp++;
      if ({button_level, press_pulse, jump_req, overrun, press_count} !== 8'h00) begin
        n_err++;
        $display("FAIL reset_outputs: got %b, expected 00000000",
                 {button_level, press_pulse, jump_req, overrun, press_count});
      end
    end
    reset = 1'b1;
    exp_q.push_back(4'd1);
    cyc(5);
    n_cmp++;
    if (press_pulse !== 1'b0 || button_level !== 1'b0) begin
      n_err++;
      $display("FAIL reset_early: got pulse=%b level=%b, expected 0 0", press_pulse, button_level);
    end
    cyc(1);
    n_cmp++;
    if (press_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL reset_latency: got pulse=%b, expected 1", press_pulse);
    end
    up_button = 1'b0;
    cyc(8);
  endtask
  task automatic test_clean_press();
    do_reset();
    up_button = 1'b1;
    exp_q.push_back(4'd1);
    cyc(5);
    n_cmp++;
    if (press_pulse !== 1'b0 || jump_req !== 1'b0) begin
      n_err++;
      $display("FAIL press_early: got pulse=%b req=%b, expected 0 0", press_pulse, jump_req);
    end
    cyc(1);
    n_cmp++;
    if ({press_pulse, jump_req, button_level, press_count} !== 7'b1110001) begin
      n_err++;
      $display("FAIL press_accept: got pulse=%b req=%b level=%b count=%0d, expected 1 1 1 1",
               press_pulse, jump_req, button_level, press_count);
    end
    cyc(1);
    n_cmp++;
    if (press_pulse !== 1'b0 || button_level !== 1'b1) begin
      n_err++;
      $display("FAIL pulse_width: got pulse=%b level=%b, expected 0 1", press_pulse, button_level);
    end
    cyc(3);
    up_button = 1'b0;
    cyc(5);
    n_cmp++;
    if (button_level !== 1'b1) begin
      n_err++;
      $display("FAIL release_early: got level=%b, expected 1", button_level);
    end
    cyc(1);
    n_cmp++;
    if (button_level !== 1'b0 || jump_req !== 1'b1) begin
      n_err++;
      $display("FAIL release_latency: got level=%b req=%b, expected 0 1", button_level, jump_req);
    end
  endtask
  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      up_button = 1'b1;
      cyc(2);
      up_button = 1'b0;
      cyc(2);
    end
    n_cmp++;
    if (button_level !== 1'b0 || press_count !== 4'd0) begin
      n_err++;
      $display("FAIL bounce_reject: got level=%b count=%0d, expected 0 0", button_level, press_count);
    end
    up_button = 1'b1;
    exp_q.push_back(4'd1);
    cyc(5);
    n_cmp++;
    if (press_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_early: got pulse=%b, expected 0", press_pulse);
    end
    cyc(1);
    n_cmp++;
    if (press_pulse !== 1'b1 || press_count !== 4'd1) begin
      n_err++;
      $display("FAIL bounce_accept: got pulse=%b count=%0d, expected 1 1", press_pulse, press_count);
    end
    up_button = 1'b0;
    cyc(8);
  endtask
  task automatic test_ack_overrun();
    do_reset();
    do_press(4'd1);
    do_press(4'd2);
    n_cmp++;
    if ({jump_req, overrun, press_count} !== 6'b110010) begin
      n_err++;
      $display("FAIL overrun_set: got req=%b ovr=%b count=%0d, expected 1 1 2", jump_req, overrun, press_count);
    end
    jump_ack = 1'b1;
    cyc(1);
    jump_ack = 1'b0;
    n_cmp++;
    if (jump_req !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ack_clear: got req=%b ovr=%b, expected 0 0", jump_req, overrun);
    end
    jump_ack = 1'b1;
    cyc(1);
    jump_ack = 1'b0;
    n_cmp++;
    if (jump_req !== 1'b0 || overrun !== 1'b0 || press_count !== 4'd2) begin
      n_err++;
      $display("FAIL ack_idle: got req=%b ovr=%b count=%0d, expected 0 0 2", jump_req, overrun, press_count);
    end
    do_press(4'd3);
    n_cmp++;
    if (jump_req !== 1'b1 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL single_press: got req=%b ovr=%b, expected 1 0", jump_req, overrun);
    end
    do_press(4'd4);
    up_button = 1'b1;
    exp_q.push_back(4'd5);
    cyc(5);
    jump_ack = 1'b1;
    cyc(1);
    jump_ack = 1'b0;
    n_cmp++;
    if ({press_pulse, jump_req, overrun} !== 3'b110) begin
      n_err++;
      $display("FAIL ack_coincident: got pulse=%b req=%b ovr=%b, expected 1 1 0", press_pulse, jump_req, overrun);
    end
    up_button = 1'b0;
    cyc(8);
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 17; i++) do_press(4'(i));
    n_cmp++;
    if (press_count !== 4'd1) begin
      n_err++;
      $display("FAIL wrap: got count=%0d, expected 1", press_count);
    end
  endtask
  task automatic test_autorepeat();
    logic rep;
`ifdef JUMP_AUTOREPEAT_EN
    rep = 1'b1;
`else
    rep = 1'b0;
`endif
    do_reset();
    up_button = 1'b1;
    exp_q.push_back(4'd1);
    cyc(6);
    for (int k = 1; k <= 4; k++) begin
      if (rep) exp_q.push_back(4'(k + 1));
      cyc(9);
      n_cmp++;
      if (press_pulse !== 1'b0) begin
        n_err++;
        $display("FAIL repeat_gap%0d: got pulse=%b, expected 0", k, press_pulse);
      end
      cyc(1);
      n_cmp++;
      if (press_pulse !== rep) begin
        n_err++;
        $display("FAIL repeat_pulse%0d: got pulse=%b, expected %b", k, press_pulse, rep);
      end
    end
    up_button = 1'b0;
    cyc(8);
    n_cmp++;
    if (press_count !== (rep ? 4'd5 : 4'd1)) begin
      n_err++;
      $display("FAIL repeat_count: got %0d, expected %0d", press_count, rep ? 5 : 1);
    end
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_ack_overrun();
    test_wrap();
    test_autorepeat();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_pulses: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
